// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: launches line fetches to a fixed-latency instruction memory,
// buffers one 64-bit line and issues 32-bit instructions over a valid/ready handshake.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [63:0] imem_ins,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [15:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        busy
);

  localparam int CW = $clog2(MEM_LATENCY + 2);

  typedef enum logic {
    FETCH = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   imem_addr_q, imem_addr_d;
  logic [63:0]   line_buf_q, line_buf_d;
  logic [12:0]   line_tag_q, line_tag_d;
  logic          line_valid_q, line_valid_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic [15:0]   pc_seq;
  logic [15:0]   pc_redir;

  assign pc_seq   = pc_q + 16'd4;
  assign pc_redir = redirect_pc & 16'hFFFC;

  // Redirect beats the handshake; a redirect that misses the buffer restarts the fetch,
  // even when the target line is the one already in flight.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_addr_d  = imem_addr_q;
    line_buf_d   = line_buf_q;
    line_tag_d   = line_tag_q;
    line_valid_d = line_valid_q;
    wait_cnt_d   = wait_cnt_q;

    if (redirect_valid) begin
      pc_d = pc_redir;
      if (line_valid_q && (pc_redir[15:3] == line_tag_q)) begin
        state_d    = SERVE;
        wait_cnt_d = '0;
      end else begin
        state_d      = FETCH;
        imem_addr_d  = {pc_redir[15:3], 3'b000};
        wait_cnt_d   = '0;
        line_valid_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (wait_cnt_q == CW'(MEM_LATENCY)) begin
            line_buf_d   = imem_ins;
            line_tag_d   = imem_addr_q[15:3];
            line_valid_d = 1'b1;
            wait_cnt_d   = '0;
            state_d      = SERVE;
          end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end
        SERVE: begin
          if (inst_ready) begin
            pc_d = pc_seq;
            if (pc_seq[15:3] != line_tag_q) begin
              imem_addr_d = {pc_seq[15:3], 3'b000};
              wait_cnt_d  = '0;
              state_d     = FETCH;
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      imem_addr_q  <= {RESET_PC[15:3], 3'b000};
      line_buf_q   <= '0;
      line_tag_q   <= '0;
      line_valid_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_addr_q  <= imem_addr_d;
      line_buf_q   <= line_buf_d;
      line_tag_q   <= line_tag_d;
      line_valid_q <= line_valid_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Outputs come straight from state flops; inst/inst_pc read as zero while fetching.
  assign imem_addr  = imem_addr_q;
  assign inst_valid = (state_q == SERVE);
  assign busy       = (state_q == FETCH);
  assign inst_pc    = inst_valid ? pc_q : 16'h0000;
  assign inst       = inst_valid ? (pc_q[2] ? line_buf_q[63:32] : line_buf_q[31:0]) : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural latency-5 instruction memory.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [63:0] imem_ins;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        busy;

  int total;
  int bad;

  localparam logic [63:0] GARBAGE = 64'hBAD0_BAD1_BAD2_BAD3;

  instruction_fetch_unit #(.RESET_PC(16'h0000), .MEM_LATENCY(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_ins      (imem_ins),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: mem[0..5] = 00..05, rest 0. The line appears on imem_ins at the 5th edge
  // with a stable address; before that the bus carries a garbage pattern.
  logic [15:0] addr_seen;
  int          age;

  function automatic logic [63:0] mem_line(input logic [15:0] a);
    if (a[15:3] == 13'd0) return 64'h0000_0504_0302_0100;
    return 64'h0;
  endfunction

  initial begin
    addr_seen = 16'hFFFF;
    age       = 0;
    imem_ins  = GARBAGE;
  end

  always @(posedge clk) begin
    if (imem_addr !== addr_seen) begin
      addr_seen <= imem_addr;
      age       <= 1;
      imem_ins  <= GARBAGE;
    end else begin
      if (age >= 4) imem_ins <= mem_line(addr_seen);
      if (age < 100) age <= age + 1;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
  endtask

  task automatic checkServe(input string tag, input logic [15:0] pc, input logic [31:0] ins);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_pc"}, {16'b0, inst_pc}, {16'b0, pc});
    checkOutput({tag, "_inst"}, inst, ins);
  endtask

  task automatic checkFetchWait(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
      checkOutput({tag, "_novalid"}, {31'b0, inst_valid}, 32'd0);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;

    // Reset state
    tick(3);
    checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd1);
    checkOutput("rst_addr", {16'b0, imem_addr}, 32'h0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_pc", {16'b0, inst_pc}, 32'h0);

    // First fetch: busy for 5 edges, capture on the 6th
    rst_n = 1'b1;
    checkFetchWait("boot", 5);
    tick(1);
    checkServe("boot_serve", 16'h0000, 32'h03020100);

    // Handshake within the line
    inst_ready = 1'b1;
    tick(1);
    checkServe("seq4", 16'h0004, 32'h00000504);

    // Stall holds outputs and address
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkServe("stall", 16'h0004, 32'h00000504);
      checkOutput("stall_addr", {16'b0, imem_addr}, 32'h0);
    end

    // Crossing into the next line fetches it with a 6-cycle bubble
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    checkOutput("cross_busy", {31'b0, busy}, 32'd1);
    checkOutput("cross_addr", {16'b0, imem_addr}, 32'h8);
    checkFetchWait("cross", 5);
    tick(1);
    checkServe("cross_serve", 16'h0008, 32'h0);

    // Redirect on the 3rd FETCH cycle aborts the line-0 fetch
    applyStimulus(16'h0000);
    checkOutput("rd0_addr", {16'b0, imem_addr}, 32'h0);
    checkOutput("rd0_busy", {31'b0, busy}, 32'd1);
    tick(2);
    applyStimulus(16'h0100);
    checkOutput("rdmid_addr", {16'b0, imem_addr}, 32'h0100);
    checkOutput("rdmid_busy", {31'b0, busy}, 32'd1);
    checkFetchWait("rdmid", 5);
    tick(1);
    checkServe("rdmid_serve", 16'h0100, 32'h0);

    // Redirect hitting the buffered line: no refetch, low bits masked, not consumed
    applyStimulus(16'h0000);
    checkFetchWait("rdline0", 5);
    tick(1);
    checkServe("line0_serve", 16'h0000, 32'h03020100);
    inst_ready = 1'b1;
    applyStimulus(16'h0006);
    inst_ready = 1'b0;
    checkServe("rdhit", 16'h0004, 32'h00000504);
    checkOutput("rdhit_addr", {16'b0, imem_addr}, 32'h0);

    // Reset for one edge mid-fetch restarts at RESET_PC
    applyStimulus(16'h0100);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checkOutput("mrst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("mrst_busy", {31'b0, busy}, 32'd1);
    checkOutput("mrst_addr", {16'b0, imem_addr}, 32'h0);
    checkOutput("mrst_inst", inst, 32'h0);
    checkOutput("mrst_pc", {16'b0, inst_pc}, 32'h0);
    checkFetchWait("mrst", 5);
    tick(1);
    checkServe("mrst_serve", 16'h0000, 32'h03020100);

    // Sequential wrap FFF8 -> FFFC -> 0000
    applyStimulus(16'hFFF8);
    checkOutput("wrap_addr", {16'b0, imem_addr}, 32'hFFF8);
    checkFetchWait("wrapf", 5);
    tick(1);
    checkServe("wrap_fff8", 16'hFFF8, 32'h0);
    inst_ready = 1'b1;
    tick(1);
    checkServe("wrap_fffc", 16'hFFFC, 32'h0);
    tick(1);
    checkOutput("wrap_busy", {31'b0, busy}, 32'd1);
    checkOutput("wrap_addr0", {16'b0, imem_addr}, 32'h0);
    checkFetchWait("wrap0", 5);
    tick(1);
    checkServe("wrap_serve0", 16'h0000, 32'h03020100);
    inst_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
